sound_arbiter: RTL and testbench
================================

Name: sound_arbiter

Overview:
- Sits between game-control logic and the per-effect sound players (jump, score, game-over); sits downstream of the players' square-wave outputs.
- Accepts one-cycle sound requests, grants at most one effect at a time by fixed priority (over > score > jump), and forwards a one-cycle start pulse to the granted player.
- Selects the granted player's wave, applies PWM volume gating, and drives the single speaker pin.

Parameters:
- JUMP_LEN, 5000000, cycles the jump effect owns the output (100 ms at 50 MHz)
- SCORE_LEN, 7500000, cycles the score effect owns the output
- OVER_LEN, 6500000, cycles the game-over effect owns the output (covers 32 × 200000-cycle periods plus margin)
- TMR_W, 25, timer width; must hold max(*_LEN)-1

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- jump_req  in  1  one-cycle jump sound request
- score_req  in  1  one-cycle score sound request
- over_req  in  1  one-cycle game-over sound request
- jump_wave  in  1  square wave from jump player
- score_wave  in  1  square wave from score player
- over_wave  in  1  square wave from game-over player
- volume  in  3  volume level, 0 = 1/8 duty, 7 = full
- mute  in  1  forces audio_out low while high
- jump_go  out  1  one-cycle start pulse to jump player
- score_go  out  1  one-cycle start pulse to score player
- over_go  out  1  one-cycle start pulse to game-over player
- audio_out  out  1  speaker drive
- busy  out  1  high while any effect is granted
- active_src  out  2  00 idle, 01 jump, 10 score, 11 over

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-low. When rst_n is low at a clk edge, the block goes to IDLE, clears the timer and the PWM counter, and drives all outputs 0.
  - No go pulse is issued in the cycle reset is released.
- States and encoding: IDLE, PLAY_JUMP, PLAY_SCORE, PLAY_OVER. active_src encodes the state directly. busy = (state != IDLE).
- Request resolution each cycle:
  - Take the highest-priority asserted request: over > score > jump.
  - The winner is granted if its priority is ≥ the current state's priority. IDLE has the lowest priority.
  - A granted request is registered: if sampled at edge N, then at edge N+1 the state becomes PLAY_x, the timer loads x_LEN-1, and x_go is high for exactly that one cycle.
  - Same-source retrigger restarts the timer and re-issues x_go.
  - A higher-priority request preempts the current effect immediately. The preempted player receives no signal.
  - Lower-priority requests are dropped, not queued.
- Timer:
  - Decrements by 1 each cycle while not IDLE.
  - When the timer is 0 and no grant occurs, the next state is IDLE.
  - Each effect therefore owns the output for exactly x_LEN cycles, including the go cycle.
  - A grant in the same cycle the timer hits 0 takes precedence over returning to IDLE.
- PWM gating:
  - 3-bit free-running pwm_cnt, incrementing every cycle and wrapping 7→0.
  - gate = (pwm_cnt <= volume).
- Output:
  - audio_out is registered: audio_out <= selected_wave & gate & ~mute, where selected_wave is taken from the current state.
  - In IDLE, audio_out <= 0.
  - Latency from a wave input to audio_out is 1 cycle.
- go outputs are mutually exclusive; at most one is high in any cycle.
- Reset mid-effect: the state is abandoned, audio_out goes 0 on the next edge, and no go pulse is issued.
- Unused wave inputs are ignored; an X on a non-selected wave must not propagate to audio_out.

Test Plan:
- Bench parameters for all scenarios: JUMP_LEN=10, SCORE_LEN=20, OVER_LEN=40.
- Jump from idle: jump_req at cycle 5 → jump_go high at cycle 6 only; active_src=01 and busy=1 for cycles 6–15; IDLE at 16. With jump_wave=1, volume=7, mute=0 → audio_out=1 during cycles 7–16.
- Preemption: jump_req at cycle 5, over_req at cycle 8 → over_go at 9; active_src=11 for cycles 9–48; no further jump_go. A score_req at 20 is dropped: no score_go, active_src stays 11.
- Simultaneous and retrigger: jump_req, score_req and over_req all at cycle 3 → only over_go at 4. Later, from PLAY_SCORE, a score_req at timer=0 → score_go is reissued, state stays PLAY_SCORE for a further 20 cycles.
- Volume, mute, reset:
  - volume=0, wave held 1 → audio_out high 1 of every 8 cycles.
  - volume=3 → high 4 of every 8 cycles.
  - mute=1 → audio_out stays 0 while the state stays PLAY_x.
  - rst_n low mid-PLAY_OVER → next edge: all outputs 0, state IDLE; the first request after reset is granted normally.

Source files
------------

// File: rtl/sound_arbiter.sv
// -----------------------------------------------------------------------------
// sound_arbiter
//
// Arbitrates one-cycle sound requests from game-control logic onto a single
// speaker pin. At most one effect owns the output at a time; priority is
// game-over > score > jump. A granted request produces a one-cycle start pulse
// to the matching player and makes that player's square wave the source for
// the speaker for a fixed number of cycles. The selected wave is gated by a
// free-running 3-bit PWM counter for volume control, and by mute.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   jump_req    one-cycle jump sound request
//   score_req   one-cycle score sound request
//   over_req    one-cycle game-over sound request
//   jump_wave   square wave from jump player
//   score_wave  square wave from score player
//   over_wave   square wave from game-over player
//   volume      3-bit volume, 0 = 1/8 duty ... 7 = full
//   mute        forces audio_out low while high
//   jump_go     one-cycle start pulse to jump player
//   score_go    one-cycle start pulse to score player
//   over_go     one-cycle start pulse to game-over player
//   audio_out   registered speaker drive
//   busy        high while any effect is granted
//   active_src  00 idle, 01 jump, 10 score, 11 over
// -----------------------------------------------------------------------------
module sound_arbiter #(
    parameter int JUMP_LEN  = 5000000,
    parameter int SCORE_LEN = 7500000,
    parameter int OVER_LEN  = 6500000,
    parameter int TMR_W     = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       jump_req,
    input  logic       score_req,
    input  logic       over_req,
    input  logic       jump_wave,
    input  logic       score_wave,
    input  logic       over_wave,
    input  logic [2:0] volume,
    input  logic       mute,
    output logic       jump_go,
    output logic       score_go,
    output logic       over_go,
    output logic       audio_out,
    output logic       busy,
    output logic [1:0] active_src
);

    // The encoding doubles as the priority rank (IDLE lowest, OVER highest)
    // and as the active_src output code.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PLAY_JUMP  = 2'b01,
        PLAY_SCORE = 2'b10,
        PLAY_OVER  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    state_t            winner;
    logic              grant;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  load_len;
    logic [2:0]        pwm_q, pwm_d;
    logic              audio_q, audio_d;
    logic              jump_go_q, jump_go_d;
    logic              score_go_q, score_go_d;
    logic              over_go_q, over_go_d;
    logic              sel_wave;
    logic              gate;

    always_comb begin
        // Highest-priority request this cycle.
        winner = IDLE;
        if (over_req) begin
            winner = PLAY_OVER;
        end else if (score_req) begin
            winner = PLAY_SCORE;
        end else if (jump_req) begin
            winner = PLAY_JUMP;
        end

        // Equal rank is allowed so a same-source request retriggers the effect;
        // lower-ranked requests are simply dropped.
        grant = (winner != IDLE) && (winner >= state_q);

        // Timer holds (cycles remaining - 1), so a load of LEN-1 gives the
        // effect exactly LEN cycles including the go cycle.
        case (winner)
            PLAY_JUMP:  load_len = TMR_W'(JUMP_LEN - 1);
            PLAY_SCORE: load_len = TMR_W'(SCORE_LEN - 1);
            PLAY_OVER:  load_len = TMR_W'(OVER_LEN - 1);
            default:    load_len = '0;
        endcase

        state_d = state_q;
        timer_d = timer_q;
        if (grant) begin
            state_d = winner;
            timer_d = load_len;
        end else if (state_q != IDLE) begin
            if (timer_q == '0) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        jump_go_d  = grant && (winner == PLAY_JUMP);
        score_go_d = grant && (winner == PLAY_SCORE);
        over_go_d  = grant && (winner == PLAY_OVER);

        // Only the owning player's wave is looked at, so an unknown level on
        // any other wave input cannot reach the speaker.
        case (state_q)
            PLAY_JUMP:  sel_wave = jump_wave;
            PLAY_SCORE: sel_wave = score_wave;
            PLAY_OVER:  sel_wave = over_wave;
            default:    sel_wave = 1'b0;
        endcase

        gate    = (pwm_q <= volume);
        audio_d = sel_wave & gate & ~mute;
        pwm_d   = pwm_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pwm_q      <= '0;
            audio_q    <= 1'b0;
            jump_go_q  <= 1'b0;
            score_go_q <= 1'b0;
            over_go_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pwm_q      <= pwm_d;
            audio_q    <= audio_d;
            jump_go_q  <= jump_go_d;
            score_go_q <= score_go_d;
            over_go_q  <= over_go_d;
        end
    end

    assign jump_go    = jump_go_q;
    assign score_go   = score_go_q;
    assign over_go    = over_go_q;
    assign audio_out  = audio_q;
    assign busy       = (state_q != IDLE);
    assign active_src = state_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sound_arbiter
//
// Directed scenarios followed by a randomized run. A reference model tracks
// the owning effect as a priority number plus a count of cycles it still owns
// the speaker, and every cycle the DUT outputs are compared against it.
// Directed scenarios also carry fixed expectations (pulse counts, durations,
// PWM duty counts).
// -----------------------------------------------------------------------------
module tb_sound_arbiter;

    localparam int JL = 10;
    localparam int SL = 20;
    localparam int OL = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       jump_req, score_req, over_req;
    logic       jump_wave, score_wave, over_wave;
    logic [2:0] volume;
    logic       mute;
    logic       jump_go, score_go, over_go;
    logic       audio_out, busy;
    logic [1:0] active_src;

    always #5 clk = ~clk;

    sound_arbiter #(
        .JUMP_LEN  (JL),
        .SCORE_LEN (SL),
        .OVER_LEN  (OL),
        .TMR_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .jump_req   (jump_req),
        .score_req  (score_req),
        .over_req   (over_req),
        .jump_wave  (jump_wave),
        .score_wave (score_wave),
        .over_wave  (over_wave),
        .volume     (volume),
        .mute       (mute),
        .jump_go    (jump_go),
        .score_go   (score_go),
        .over_go    (over_go),
        .audio_out  (audio_out),
        .busy       (busy),
        .active_src (active_src)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner priority (0 idle .. 3 over), cycles remaining.
    int   m_cur = 0;
    int   m_rem = 0;
    int   m_go  = 0;
    int   m_pwm = 0;
    logic m_audio = 1'b0;

    function automatic int len_of(input int src);
        case (src)
            1:       return JL;
            2:       return SL;
            3:       return OL;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] model_vec();
        return {m_go == 1, m_go == 2, m_go == 3, m_audio, m_cur != 0, 2'(m_cur)};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {jump_go, score_go, over_go, audio_out, busy, active_src};
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int   win;
        logic sel;
        if (!rst_n) begin
            m_cur = 0; m_rem = 0; m_go = 0; m_audio = 1'b0; m_pwm = 0;
        end else begin
            if (m_cur == 0) begin
                m_audio = 1'b0;
            end else begin
                sel = (m_cur == 1) ? jump_wave : (m_cur == 2) ? score_wave : over_wave;
                m_audio = sel & (m_pwm <= int'(volume)) & ~mute;
            end
            win = over_req ? 3 : score_req ? 2 : jump_req ? 1 : 0;
            if (win != 0 && win >= m_cur) begin
                m_cur = win;
                m_rem = len_of(win);
                m_go  = win;
            end else begin
                m_go = 0;
                if (m_cur != 0) begin
                    m_rem--;
                    if (m_rem == 0) m_cur = 0;
                end
            end
            m_pwm = (m_pwm + 1) % 8;
        end
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (go_j,go_s,go_o,audio,busy,src)", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge: inputs were set at the previous negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(tag, dut_vec(), model_vec());
    endtask

    task automatic pulse(input logic j, input logic s, input logic o, input string tag);
        jump_req = j; score_req = s; over_req = o;
        step(tag);
        jump_req = 1'b0; score_req = 1'b0; over_req = 1'b0;
    endtask

    int busy_cnt, audio_cnt, go_cnt;

    initial begin
        rst_n = 1'b0;
        jump_req = 1'b0; score_req = 1'b0; over_req = 1'b0;
        jump_wave = 1'b1; score_wave = 1'b1; over_wave = 1'b1;
        volume = 3'd7; mute = 1'b0;

        // Reset state.
        repeat (3) step("reset");
        check("reset_all_zero", dut_vec(), 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("release");
        check("no_go_after_release", {jump_go, score_go, over_go}, 3'b000);

        // Jump from idle: 10 busy cycles, audio high for 10 cycles one later.
        pulse(1'b1, 1'b0, 1'b0, "jump_go");
        check("jump_go_src", {jump_go, active_src}, 3'b101);
        busy_cnt = 1; audio_cnt = int'(audio_out);
        for (int i = 0; i < 14; i++) begin
            step("jump_play");
            busy_cnt  += int'(busy);
            audio_cnt += int'(audio_out);
        end
        check_int("jump_busy_cycles", busy_cnt, JL);
        check_int("jump_audio_cycles", audio_cnt, JL);

        // Preemption by over, lower-priority score dropped.
        pulse(1'b1, 1'b0, 1'b0, "pre_jump");
        repeat (2) step("pre_jump_play");
        pulse(1'b0, 1'b0, 1'b1, "pre_over");
        check("preempt_over_go", {jump_go, score_go, over_go, active_src}, 5'b00111);
        go_cnt = 0; busy_cnt = 1;
        for (int i = 0; i < 10; i++) begin
            step("pre_over_play");
            go_cnt += int'(jump_go) + int'(score_go);
            busy_cnt += int'(busy);
        end
        pulse(1'b0, 1'b1, 1'b0, "drop_score");
        check("score_dropped", {score_go, active_src}, 3'b011);
        busy_cnt += int'(busy);
        for (int i = 0; i < 35; i++) begin
            step("pre_over_tail");
            go_cnt += int'(jump_go) + int'(score_go);
            busy_cnt += int'(busy);
        end
        check_int("no_extra_go", go_cnt, 0);
        check_int("over_busy_cycles", busy_cnt, OL);

        // Simultaneous requests: only over wins.
        pulse(1'b1, 1'b1, 1'b1, "simul");
        check("simul_over_only", {jump_go, score_go, over_go, active_src}, 5'b00111);
        repeat (OL) step("simul_play");
        check_int("simul_idle", int'(busy), 0);

        // Retrigger score exactly on its last owned cycle.
        pulse(1'b0, 1'b1, 1'b0, "score_go");
        repeat (SL - 1) step("score_play");
        pulse(1'b0, 1'b1, 1'b0, "retrigger");
        check("retrigger_go", {score_go, active_src}, 3'b110);
        busy_cnt = 1;
        for (int i = 0; i < SL + 3; i++) begin
            step("retrigger_play");
            busy_cnt += int'(busy);
        end
        check_int("retrigger_cycles", busy_cnt, SL);

        // Volume duty counts over 32 cycles, then mute; non-selected waves X.
        for (int v = 0; v < 3; v++) begin
            volume = (v == 0) ? 3'd0 : 3'd3;
            mute   = (v == 2);
            score_wave = 1'bx; jump_wave = 1'bx;
            pulse(1'b0, 1'b0, 1'b1, "vol_over");
            audio_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                step("vol_play");
                audio_cnt += (audio_out === 1'b1) ? 1 : 0;
            end
            check_int(v == 0 ? "vol0_duty" : v == 1 ? "vol3_duty" : "mute_duty",
                      audio_cnt, v == 0 ? 4 : v == 1 ? 16 : 0);
            repeat (10) step("vol_tail");
            check_int("vol_idle_audio_known", int'(audio_out === 1'b0), 1);
        end
        score_wave = 1'b1; jump_wave = 1'b1; mute = 1'b0; volume = 3'd7;

        // Reset in the middle of game-over, then a normal grant.
        pulse(1'b0, 1'b0, 1'b1, "rst_over");
        repeat (5) step("rst_over_play");
        rst_n = 1'b0;
        over_req = 1'b1;
        step("mid_reset");
        over_req = 1'b0;
        check("mid_reset_zero", dut_vec(), 7'b0);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, "post_reset_jump");
        check("post_reset_grant", {jump_go, active_src}, 3'b101);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            jump_req   = ($urandom_range(15) == 0);
            score_req  = ($urandom_range(23) == 0);
            over_req   = ($urandom_range(47) == 0);
            jump_wave  = $urandom_range(1);
            score_wave = $urandom_range(1);
            over_wave  = $urandom_range(1);
            if ($urandom_range(63) == 0) volume = 3'($urandom_range(7));
            if ($urandom_range(63) == 0) mute = $urandom_range(1);
            rst_n = ($urandom_range(499) != 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
